// File: rtl/reg_bus_master_if.sv
// reg_bus_master_if: the host command/response channels and the register-bus strobes of reg_bus_master.
// Ports: cmd_* (host -> master, valid/ready), rsp_* (master -> host, valid/ready),
//        wr_en/rd_en/addr/write_data (master -> regfile decoder), read_data (decoder -> master, combinational).
interface reg_bus_master_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  // host command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] cmd_mask;

  // host response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic              rsp_err;

  // register bus
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  // the bus master itself
  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready, read_data,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, rsp_err,
           wr_en, rd_en, addr, write_data
  );

  // host bridge + register decoder side
  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready, read_data,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, rsp_err,
           wr_en, rd_en, addr, write_data
  );
endinterface

// File: rtl/reg_bus_master.sv
// reg_bus_master: register-bus initiator executing one host command at a time (write, read, masked poll).
// Latency: strobe one cycle after accept; response two cycles after accept (poll: one cycle after the matching/last read).
// Backpressure: cmd_ready only while idle; the response is held stable until rsp_ready, no command queue.
// Ports: clk, rst_n (async active-low), bus (reg_bus_master_if.master: cmd_*, rsp_*, wr_en/rd_en/addr/write_data/read_data).
module reg_bus_master #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 16,
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  reg_bus_master_if.master    bus
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);
  // the gap counter loads POLL_GAP-1 and counts down to zero
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, POLL_RD, POLL_WAIT, ERR, RESP
  } state_t;

  state_t            state;
  logic              wr_en_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] exp_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] rdata_q;
  logic              timeout_q;
  logic              err_q;
  logic              rsp_valid_q;
  logic [CNT_W-1:0]  attempts;
  logic [GAP_W-1:0]  gap_cnt;

  logic [CNT_W-1:0]  attempts_nxt;
  logic              poll_hit;
  logic              poll_last;

  // count includes the read happening this cycle
  assign attempts_nxt = attempts + CNT_W'(1);
  // a zero mask makes every read a hit
  assign poll_hit     = ((bus.read_data ^ exp_q) & mask_q) == '0;
  assign poll_last    = (attempts_nxt == CNT_W'(POLL_MAX));

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_timeout = timeout_q;
  assign bus.rsp_err     = err_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.addr        = addr_q;
  assign bus.write_data  = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      exp_q       <= '0;
      mask_q      <= '0;
      rdata_q     <= '0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      attempts    <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            attempts  <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            case (bus.cmd_op)
              OP_WRITE: begin
                state   <= WRITE;
                wr_en_q <= 1'b1;
                addr_q  <= bus.cmd_addr;
                wdata_q <= bus.cmd_wdata;
              end
              OP_READ: begin
                state   <= READ;
                rd_en_q <= 1'b1;
                addr_q  <= bus.cmd_addr;
              end
              OP_POLL: begin
                state   <= POLL_RD;
                rd_en_q <= 1'b1;
                addr_q  <= bus.cmd_addr;
                exp_q   <= bus.cmd_wdata;
                mask_q  <= bus.cmd_mask;
              end
              default: state <= ERR;
            endcase
          end
        end

        WRITE: begin
          wr_en_q     <= 1'b0;
          rdata_q     <= '0;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end

        READ: begin
          rd_en_q     <= 1'b0;
          rdata_q     <= bus.read_data;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end

        POLL_RD: begin
          attempts <= attempts_nxt;
          rdata_q  <= bus.read_data;
          if (poll_hit || poll_last) begin
            rd_en_q     <= 1'b0;
            timeout_q   <= ~poll_hit;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else if (POLL_GAP == 0) begin
            // back-to-back reads: keep the strobe up and stay here
            rd_en_q <= 1'b1;
            state   <= POLL_RD;
          end else begin
            rd_en_q <= 1'b0;
            gap_cnt <= GAP_W'(POLL_GAP - 1);
            state   <= POLL_WAIT;
          end
        end

        POLL_WAIT: begin
          if (gap_cnt == '0) begin
            rd_en_q <= 1'b1;
            state   <= POLL_RD;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        ERR: begin
          rdata_q     <= '0;
          err_q       <= 1'b1;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: directed bench for reg_bus_master with a response scoreboard and strobe logging.
// Ports: none; drives the slave side of reg_bus_master_if and models the register decoder's read_data.
module tb_reg_bus_master;
  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 16;
  localparam int POLL_GAP = 4;
  localparam int POLL_MAX = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reg_bus_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] rdata;
    logic        timeout;
    logic        err;
    int          rise;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  int   cyc = 0;
  int   rd_total = 0;
  int   rd_base = 0;
  logic seq_mode = 1'b0;
  logic [15:0] seq [16];

  int   wr_cyc[$];
  int   rd_cyc[$];
  int   both_hi = 0;
  int   rsp_cnt = 0;
  int   rise_cyc = -1;
  logic prev_vld = 1'b0;
  exp_t e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rd_en) rd_total <= rd_total + 1;
  end

  // register decoder model: fixed map, or a scripted sequence indexed by read count
  always_comb begin
    int idx;
    idx = rd_total - rd_base;
    if (idx > 15) idx = 15;
    if (idx < 0) idx = 0;
    if (seq_mode) bus.read_data = seq[idx];
    else bus.read_data = (bus.addr == 14'h101) ? 16'hBEEF : 16'h5A5A;
  end

  // strobe log and response scoreboard
  always @(negedge clk) begin
    if (bus.wr_en) wr_cyc.push_back(cyc);
    if (bus.rd_en) rd_cyc.push_back(cyc);
    if (bus.wr_en && bus.rd_en) both_hi++;
    if (bus.rsp_valid && !prev_vld) rise_cyc = cyc;
    if (bus.rsp_valid && bus.rsp_ready) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(bus.rsp_valid), 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata",   32'(bus.rsp_rdata),   32'(e.rdata));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.timeout));
        chk("rsp_err",     32'(bus.rsp_err),     32'(e.err));
        chk("rsp_rise",    rise_cyc,             e.rise);
      end
    end
    prev_vld = bus.rsp_valid;
  end

  task automatic expect_rsp(input logic [15:0] rd, input logic to, input logic er, input int rise);
    exp_t x;
    x.rdata = rd; x.timeout = to; x.err = er; x.rise = rise;
    sb.push_back(x);
  endtask

  // called at a negedge; returns at the negedge of cycle N+1, n = accept cycle N
  task automatic send(input logic [1:0] op, input logic [13:0] a, input logic [15:0] wd,
                      input logic [15:0] mk, output int n);
    int t;
    t = 0;
    while (!bus.cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("cmd_ready_wait", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_mask  = mk;
    n = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 14'h3FFF;
    bus.cmd_wdata = 16'hDEAD;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (!(sb.size() == 0 && bus.cmd_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk(tag, 32'(sb.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int saved;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_mask  = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) seq[i] = 16'h0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_wr_en",      32'(bus.wr_en),       0);
    chk("rst_rd_en",      32'(bus.rd_en),       0);
    chk("rst_addr",       32'(bus.addr),        0);
    chk("rst_write_data", 32'(bus.write_data),  0);
    chk("rst_rsp_valid",  32'(bus.rsp_valid),   0);
    chk("rst_rsp_rdata",  32'(bus.rsp_rdata),   0);
    chk("rst_rsp_err",    32'(bus.rsp_err),     0);
    chk("rst_cmd_ready",  32'(bus.cmd_ready),   1);
    rst_n = 1'b1;
    @(negedge clk);

    // single write
    wr_cyc.delete(); rd_cyc.delete();
    send(2'b00, 14'h108, 16'h0302, 16'hFFFF, n);
    expect_rsp(16'h0000, 1'b0, 1'b0, n + 2);
    chk("wr_strobe",     32'(bus.wr_en),      1);
    chk("wr_addr",       32'(bus.addr),       32'h108);
    chk("wr_data",       32'(bus.write_data), 32'h0302);
    chk("wr_cmd_ready",  32'(bus.cmd_ready),  0);
    wait_idle("wr_done");
    chk("wr_pulses",     32'(wr_cyc.size()),  1);
    chk("wr_pulse_cyc",  wr_cyc[0],           n + 1);
    chk("wr_no_rd",      32'(rd_cyc.size()),  0);
    chk("wr_addr_hold",  32'(bus.addr),       32'h108);

    // single read
    rd_cyc.delete();
    send(2'b01, 14'h101, 16'h0, 16'h0, n);
    expect_rsp(16'hBEEF, 1'b0, 1'b0, n + 2);
    chk("rd_strobe",     32'(bus.rd_en),      1);
    chk("rd_rdy_n1",     32'(bus.cmd_ready),  0);
    @(negedge clk);
    chk("rd_rdy_n2",     32'(bus.cmd_ready),  0);
    chk("rd_rdata_n2",   32'(bus.rsp_rdata),  32'hBEEF);
    @(negedge clk);
    chk("rd_rdy_n3",     32'(bus.cmd_ready),  1);
    wait_idle("rd_done");
    chk("rd_pulses",     32'(rd_cyc.size()),  1);
    chk("rd_pulse_cyc",  rd_cyc[0],           n + 1);
    chk("rd_wdata_hold", 32'(bus.write_data), 32'h0302);

    // poll: match on third read
    seq[0] = 16'h0000; seq[1] = 16'h0001;
    for (int i = 2; i < 16; i++) seq[i] = 16'h00F2;
    rd_base = rd_total; seq_mode = 1'b1; rd_cyc.delete();
    send(2'b10, 14'h111, 16'h0002, 16'h000F, n);
    expect_rsp(16'h00F2, 1'b0, 1'b0, n + 12);
    wait_idle("poll_done");
    chk("poll_pulses",   32'(rd_cyc.size()),  3);
    chk("poll_rd1",      rd_cyc[0],           n + 1);
    chk("poll_rd2",      rd_cyc[1],           n + 6);
    chk("poll_rd3",      rd_cyc[2],           n + 11);

    // poll timeout: never matches
    for (int i = 0; i < 16; i++) seq[i] = 16'h0010 + 16'(i);
    rd_base = rd_total; rd_cyc.delete();
    send(2'b10, 14'h111, 16'h000F, 16'h00FF, n);
    expect_rsp(16'h0017, 1'b1, 1'b0, n + 1 + (POLL_MAX - 1) * (POLL_GAP + 1) + 1);
    wait_idle("to_done");
    chk("to_pulses",     32'(rd_cyc.size()),  POLL_MAX);
    chk("to_last_rd",    rd_cyc[POLL_MAX-1],  n + 1 + (POLL_MAX - 1) * (POLL_GAP + 1));

    // poll with zero mask hits on the first read
    seq_mode = 1'b0; rd_cyc.delete();
    send(2'b10, 14'h101, 16'h1234, 16'h0000, n);
    expect_rsp(16'hBEEF, 1'b0, 1'b0, n + 2);
    wait_idle("mask0_done");
    chk("mask0_pulses",  32'(rd_cyc.size()),  1);

    // reserved op with response backpressure
    bus.rsp_ready = 1'b0; wr_cyc.delete(); rd_cyc.delete();
    send(2'b11, 14'h055, 16'h1234, 16'h0, n);
    expect_rsp(16'h0000, 1'b0, 1'b1, n + 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("err_vld_held", 32'(bus.rsp_valid), 1);
      chk("err_flag",     32'(bus.rsp_err),   1);
      chk("err_rdy_low",  32'(bus.cmd_ready), 0);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("err_rdy_back",  32'(bus.cmd_ready),  1);
    chk("err_no_wr",     32'(wr_cyc.size()),  0);
    chk("err_no_rd",     32'(rd_cyc.size()),  0);

    // reset while waiting between poll reads
    for (int i = 0; i < 16; i++) seq[i] = 16'h0010 + 16'(i);
    rd_base = rd_total; seq_mode = 1'b1; rd_cyc.delete();
    saved = rsp_cnt;
    send(2'b10, 14'h111, 16'h000F, 16'h00FF, n);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_rd_en",      32'(bus.rd_en),      0);
    chk("mr_wr_en",      32'(bus.wr_en),      0);
    chk("mr_addr",       32'(bus.addr),       0);
    chk("mr_write_data", 32'(bus.write_data), 0);
    chk("mr_rsp_valid",  32'(bus.rsp_valid),  0);
    chk("mr_rsp_rdata",  32'(bus.rsp_rdata),  0);
    chk("mr_rsp_timeout",32'(bus.rsp_timeout),0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("mr_reads",      32'(rd_cyc.size()),  1);
    chk("mr_no_rsp",     rsp_cnt,             saved);
    seq_mode = 1'b0;
    send(2'b01, 14'h101, 16'h0, 16'h0, n);
    expect_rsp(16'hBEEF, 1'b0, 1'b0, n + 2);
    wait_idle("mr_read_done");
    chk("mr_read_cyc",   rd_cyc[1],           n + 1);

    chk("never_both",    both_hi,             0);
    chk("sb_empty",      32'(sb.size()),      0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
